// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by the prefetch FIFO and the fetch unit top.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_e;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] EMPTY_WORD      = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush.
// Head reads as all-zero while the FIFO is empty.
import fetch_pkg::*;

module fetch_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_comb begin
    rdata.pc    = EMPTY_WORD;
    rdata.instr = EMPTY_WORD;
    if (!empty)
      rdata = mem_q[rptr_q];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues imem word requests against reserved
// FIFO slots and hands {pc, instr} to decode; flushes on redirect.
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;

  logic          push, pop, empty, slot_free;
  logic [CW-1:0] count, occ_next;
  logic [31:0]   redir_pc, pc_inc;
  fetch_entry_t  wentry, head;

  assign redir_pc = redirect_pc & WORD_ALIGN_MASK;
  assign pc_inc   = pc_q + 32'(INSTR_BYTES);

  assign pop  = instr_valid && instr_ready;
  assign push = (state_q == WAIT) && imem_ack && !redirect_valid;

  // Occupancy after this edge; a request is only raised into a free slot
  assign occ_next  = redirect_valid ? '0
                   : count + CW'(push) - CW'(pop);
  assign slot_free = (occ_next < CW'(FIFO_DEPTH));

  assign wentry.pc    = pc_q;
  assign wentry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else if (slot_free) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (slot_free) begin
            addr_d = pc_inc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (redirect_valid)
          pc_d = redir_pc;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small
// variable-latency instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int unsigned mem_delay;
  int unsigned wcnt;
  int          n_ack = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] pop_pc [$];
  logic [31:0] pop_ins [$];

  instr_fetch_unit #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (wcnt >= mem_delay);
  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

  always @(posedge clk or posedge reset) begin
    if (reset)         wcnt <= 0;
    else if (imem_ack) wcnt <= 0;
    else if (imem_req) wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (imem_ack) n_ack <= n_ack + 1;
    if (!reset && instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_at(input int i);
    if (i < pop_pc.size()) return pop_pc[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    if (i < pop_ins.size()) return pop_ins[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   a0;
    int   b;
    logic found;

    reset          = 1'b1;
    mem_delay      = 0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(2);
    chk("rst_req",   imem_req,    0);
    chk("rst_addr",  imem_addr,   0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr,       0);
    chk("rst_pc",    instr_pc,    0);

    // zero-wait fill, consumer stalled
    a0    = n_ack;
    reset = 1'b0;
    tick(1);
    chk("t1_req_rise", imem_req,    1);
    chk("t1_addr0",    imem_addr,   0);
    chk("t1_novalid",  instr_valid, 0);
    tick(1);
    chk("t1_valid",    instr_valid, 1);
    chk("t1_head_pc",  instr_pc,    32'h0);
    chk("t1_head_ins", instr,       32'hA5A5_A5A5);
    chk("t1_addr4",    imem_addr,   32'h4);
    tick(1);
    chk("t1_addr8",    imem_addr,   32'h8);
    tick(5);
    chk("t1_ack4",     n_ack - a0,  4);
    chk("t1_req_drop", imem_req,    0);

    b           = pop_pc.size();
    instr_ready = 1'b1;
    tick(1);
    chk("t1_resume_req",  imem_req,  1);
    chk("t1_resume_addr", imem_addr, 32'h10);
    tick(6);
    chk("t1_pop0",    pc_at(b),      32'h0);
    chk("t1_pop1",    pc_at(b + 1),  32'h4);
    chk("t1_pop2",    pc_at(b + 2),  32'h8);
    chk("t1_pop3",    pc_at(b + 3),  32'hC);
    chk("t1_pop4",    pc_at(b + 4),  32'h10);
    chk("t1_pop4ins", ins_at(b + 4), 32'hA5A5_A5B5);

    // redirect during a slow memory access
    reset     = 1'b1;
    mem_delay = 3;
    tick(1);
    reset = 1'b0;
    b     = pop_pc.size();
    tick(1);
    chk("t3_req",  imem_req,  1);
    chk("t3_addr", imem_addr, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick(1);
    redirect_valid = 1'b0;
    chk("t3_hold_req",  imem_req,  1);
    chk("t3_hold_addr", imem_addr, 0);
    tick(1);
    chk("t3_hold_addr2", imem_addr,   0);
    chk("t3_novalid",    instr_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (imem_req && imem_addr == 32'h100) found = 1'b1;
    end
    chk("t3_newaddr", found, 1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (pop_pc.size() > b) found = 1'b1;
    end
    chk("t3_popped",  found,     1);
    chk("t3_pop_pc",  pc_at(b),  32'h100);
    chk("t3_pop_ins", ins_at(b), 32'hA5A5_A4A5);

    // redirect coincident with ack
    reset       = 1'b1;
    mem_delay   = 0;
    instr_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("t4_req",  imem_req,  1);
    chk("t4_addr", imem_addr, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick(1);
    redirect_valid = 1'b0;
    chk("t4_drop_req", imem_req,    0);
    chk("t4_empty",    instr_valid, 0);
    tick(1);
    chk("t4_req2",   imem_req,    1);
    chk("t4_addr2",  imem_addr,   32'h200);
    chk("t4_empty2", instr_valid, 0);
    tick(1);
    chk("t4_valid",    instr_valid, 1);
    chk("t4_head_pc",  instr_pc,    32'h200);
    chk("t4_head_ins", instr,       32'hA5A5_A7A5);

    // fetch PC wraps past the top of the address space
    reset       = 1'b1;
    instr_ready = 1'b1;
    tick(1);
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    b              = pop_pc.size();
    tick(1);
    redirect_valid = 1'b0;
    chk("t5_noreq", imem_req, 0);
    tick(1);
    chk("t5_req",  imem_req,  1);
    chk("t5_addr", imem_addr, 32'hFFFF_FFF8);
    tick(6);
    chk("t5_pop0",    pc_at(b),      32'hFFFF_FFF8);
    chk("t5_pop0ins", ins_at(b),     32'h5A5A_5A5D);
    chk("t5_pop1",    pc_at(b + 1),  32'hFFFF_FFFC);
    chk("t5_pop2",    pc_at(b + 2),  32'h0000_0000);
    chk("t5_pop2ins", ins_at(b + 2), 32'hA5A5_A5A5);

    // async reset with entries buffered and a request outstanding
    reset       = 1'b1;
    instr_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("t6_valid",  instr_valid, 1);
    chk("t6_req",    imem_req,    1);
    chk("t6_addr",   imem_addr,   32'hC);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_req",   imem_req,    0);
    chk("t6_rst_addr",  imem_addr,   0);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_instr", instr,       0);
    chk("t6_rst_pc",    instr_pc,    0);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("t6_refetch_req",  imem_req,    1);
    chk("t6_refetch_addr", imem_addr,   0);
    chk("t6_refetch_nv",   instr_valid, 0);
    tick(1);
    chk("t6_head_pc",  instr_pc, 32'h0);
    chk("t6_head_ins", instr,    32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
